// File: rtl/bus_mux_reg.sv
// Registered one-hot bus multiplexer with hold, conflict detection and a saturating transfer counter.
// Optional `BUS_MUX_PRIORITY_EN: multi-driver cycles resolve to the lowest requesting source.
module bus_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_out,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         bus_src,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CNT_W-1:0]         xfer_count
);

    logic             any_req;
    logic             multi_req;
    logic [SEL_W-1:0] low_idx;
    logic [WIDTH-1:0] low_word;
    logic             load;

    // Scan from the top down so the lowest requesting source is the one left behind.
    always_comb begin
        any_req   = 1'b0;
        multi_req = 1'b0;
        low_idx   = '0;
        low_word  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                if (any_req) multi_req = 1'b1;
                any_req  = 1'b1;
                low_idx  = SEL_W'(i);
                low_word = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef BUS_MUX_PRIORITY_EN
    assign load = any_req;
`else
    assign load = any_req && !multi_req;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_out         <= '0;
            bus_valid       <= 1'b0;
            bus_src         <= '0;
            conflict        <= 1'b0;
            conflict_sticky <= 1'b0;
            xfer_count      <= '0;
        end else begin
            conflict <= multi_req;
            if (multi_req)
                conflict_sticky <= 1'b1;
            else if (err_clr)
                conflict_sticky <= 1'b0;

            if (load) begin
                bus_out   <= low_word;
                bus_src   <= low_idx;
                bus_valid <= 1'b1;
                if (xfer_count != {CNT_W{1'b1}})
                    xfer_count <= xfer_count + 1'b1;
            end else begin
                bus_valid <= 1'b0;
                // A non-resolved conflict blanks the bus rather than passing a wired-OR word.
                if (multi_req)
                    bus_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Randomized + directed bench for bus_mux_reg against a behavioural bus model.
module tb_bus_mux_reg;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 24;
    localparam int SEL_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BUS_MUX_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_out;
    logic                     err_clr;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [SEL_W-1:0]         bus_src;
    logic                     conflict;
    logic                     conflict_sticky;
    logic [CNT_W-1:0]         xfer_count;

    logic [WIDTH-1:0] words [NUM_SRC];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [WIDTH-1:0] m_bus;
    int               m_src;
    bit               m_valid, m_conf, m_sticky;
    int               m_cnt;

    bus_mux_reg #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .src_data(src_data), .src_out(src_out),
        .err_clr(err_clr), .bus_out(bus_out), .bus_valid(bus_valid), .bus_src(bus_src),
        .conflict(conflict), .conflict_sticky(conflict_sticky), .xfer_count(xfer_count)
    );

    always #5 clock = ~clock;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = words[i];
    end

    function automatic int lowest(input logic [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Behavioural model: classify by population count, resolve to lowest index.
    always @(posedge clock) begin
        if (reset) begin
            m_bus <= '0; m_src <= 0; m_valid <= 0; m_conf <= 0; m_sticky <= 0; m_cnt <= 0;
        end else begin
            m_conf   <= ($countones(src_out) >= 2);
            m_sticky <= ($countones(src_out) >= 2) ? 1'b1 : (err_clr ? 1'b0 : m_sticky);
            if ($countones(src_out) == 1 || (PRIO && $countones(src_out) >= 2)) begin
                m_bus   <= words[lowest(src_out)];
                m_src   <= lowest(src_out);
                m_valid <= 1'b1;
                m_cnt   <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else begin
                m_valid <= 1'b0;
                if ($countones(src_out) >= 2) m_bus <= '0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("bus_out",  64'(bus_out), 64'(m_bus));
            chk("bus_src",  64'(bus_src), 64'(m_src));
            chk("bus_valid", 64'(bus_valid), 64'(m_valid));
            chk("conflict", 64'(conflict), 64'(m_conf));
            chk("sticky",   64'(conflict_sticky), 64'(m_sticky));
            chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
            chk("valid_conf_excl", 64'(bus_valid && conflict && !PRIO), 64'(0));
        end
    end

    task automatic step(input logic [NUM_SRC-1:0] so, input logic rst, input logic clr);
        #1;
        src_out = so; reset = rst; err_clr = clr;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [NUM_SRC-1:0] bit_of(input int k);
        logic [NUM_SRC-1:0] one;
        one = 1;
        return one << k;
    endfunction

    initial begin
        logic [NUM_SRC-1:0] so;
        int r;
        reset = 1'b1; err_clr = 1'b0; src_out = '0;
        for (int i = 0; i < NUM_SRC; i++) words[i] = $urandom;

        // Reset with random requests, then idle
        step(NUM_SRC'($urandom), 1'b1, 1'b0);
        chk_en = 1'b1;
        step(NUM_SRC'($urandom), 1'b1, 1'b0);
        chk("rst_bus", 64'(bus_out), 64'h0);
        chk("rst_cnt", 64'(xfer_count), 64'h0);
        chk("rst_sticky", 64'(conflict_sticky), 64'h0);
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0);
        chk("idle_bus", 64'(bus_out), 64'h0);
        chk("idle_valid", 64'(bus_valid), 64'h0);

        // Single drives then hold
        words[3] = 32'h0000_00A5; words[21] = 32'hDEAD_BEEF;
        step(bit_of(3), 1'b0, 1'b0);
        chk("r3_bus", 64'(bus_out), 64'hA5);
        chk("r3_src", 64'(bus_src), 64'd3);
        step(bit_of(21), 1'b0, 1'b0);
        chk("mdr_bus", 64'(bus_out), 64'hDEAD_BEEF);
        chk("mdr_src", 64'(bus_src), 64'd21);
        step('0, 1'b0, 1'b0);
        chk("hold_bus", 64'(bus_out), 64'hDEAD_BEEF);
        chk("hold_valid", 64'(bus_valid), 64'h0);
        chk("two_xfers", 64'(xfer_count), 64'd2);

        // Conflict
        words[2] = 32'h11; words[7] = 32'h77;
        step(bit_of(2) | bit_of(7), 1'b0, 1'b0);
        chk("conf_pulse", 64'(conflict), 64'h1);
        chk("conf_sticky", 64'(conflict_sticky), 64'h1);
        chk("conf_bus", 64'(bus_out), PRIO ? 64'h11 : 64'h0);
        chk("conf_valid", 64'(bus_valid), PRIO ? 64'h1 : 64'h0);
        chk("conf_src", 64'(bus_src), PRIO ? 64'd2 : 64'd21);
        step('0, 1'b0, 1'b0);
        chk("conf_drop", 64'(conflict), 64'h0);

        // Sticky set wins over clear, then clears
        step(bit_of(2) | bit_of(7), 1'b0, 1'b1);
        chk("race_sticky", 64'(conflict_sticky), 64'h1);
        step('0, 1'b0, 1'b1);
        chk("clr_sticky", 64'(conflict_sticky), 64'h0);

        // Counter saturation
        step('0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            words[i % NUM_SRC] = $urandom;
            step(bit_of($urandom_range(0, NUM_SRC - 1)), 1'b0, 1'b0);
        end
        chk("sat_cnt", 64'(xfer_count), 64'd15);

        // Reset mid-stream
        words[19] = 32'h1234;
        for (int i = 0; i < 4; i++) step((i % 2 == 0) ? bit_of(19) : '0, 1'b0, 1'b0);
        step(bit_of(19), 1'b1, 1'b0);
        chk("mid_rst_bus", 64'(bus_out), 64'h0);
        chk("mid_rst_valid", 64'(bus_valid), 64'h0);
        chk("mid_rst_cnt", 64'(xfer_count), 64'h0);
        step(bit_of(19), 1'b0, 1'b0);
        chk("resume_bus", 64'(bus_out), 64'h1234);
        chk("resume_src", 64'(bus_src), 64'd19);
        chk("resume_cnt", 64'(xfer_count), 64'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_SRC; i++) words[i] = $urandom;
            r = $urandom_range(0, 99);
            if (r < 35)      so = '0;
            else if (r < 80) so = bit_of($urandom_range(0, NUM_SRC - 1));
            else if (r < 95) so = bit_of($urandom_range(0, NUM_SRC - 1)) | bit_of($urandom_range(0, NUM_SRC - 1));
            else             so = NUM_SRC'($urandom);
            step(so, ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
